fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register. It consumes the decode-stage control decisions (`Branch` from the branch unit, jump flags from the controller, forwarded `jr` target) and produces the D-stage instruction, PC and link values. One architectural delay slot applies. A pending-redirect register keeps a branch or jump decision that arrives while instruction memory is not ready.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset. Sampled only on the rising edge of `clk`.
- `Stall` in 1: from the hazard unit. Freezes the PC, the IF/ID register and the pending-redirect register.
- `Branch` in 1: branch-taken decision for the instruction currently in D.
- `IfJ` in 1: the D instruction is `j`.
- `IfJal` in 1: the D instruction is `jal`.
- `IfJr` in 1: the D instruction is `jr`.
- `JrTarget` in 32: forwarded rs value used by `jr`.
- `imem_addr` out 32: fetch address; always equal to `PCF`.
- `imem_rdata` in 32: instruction word at `imem_addr`; combinational, same cycle.
- `imem_ready` in 1: `imem_rdata` is valid this cycle.
- `PCF` out 32: current fetch PC.
- `InstrD` out 32: IF/ID instruction.
- `PCD` out 32: IF/ID PC.
- `PCPlus4D` out 32: `PCD+4`.
- `PCPlus8D` out 32: `PCD+8`, the `jal` link value.
- `ValidD` out 1: IF/ID holds a real instruction; 0 means bubble.

## Operation
Derived terms:
- `redirect = ValidD & (Branch | IfJ | IfJal | IfJr)`.
- `target` priority:
  - `IfJr` selects `JrTarget`.
  - else `IfJ | IfJal` selects `{PCPlus4D[31:28], InstrD[25:0], 2'b00}`.
  - else `Branch` selects `PCPlus4D + {{14{InstrD[15]}}, InstrD[15:0], 2'b00}`.
- All additions are 32-bit modulo 2^32. Carry-out is dropped and the PC wraps.
- No alignment checking: `target[1:0]` passes through unchanged.

Internal state: `PCF`, IF/ID register `{InstrD, PCD, ValidD}`, and `pend_v` with `pend_pc[31:0]`. The two-state redirect FSM is IDLE when `pend_v=0` and PENDING when `pend_v=1`.

Per rising edge, when `reset_n=1`:
- `Stall=1`: every register holds. `imem_ready` and `redirect` are ignored. Decode re-evaluates `Branch` on the held instruction next cycle.
- `Stall=0`, `imem_ready=1` (fetch completes):
  - IF/ID loads `{imem_rdata, PCF, 1}`.
  - `PCF` loads `target` if `redirect`; else `pend_pc` if `pend_v`; else `PCF+4`.
  - `pend_v` goes to 0, so the FSM returns to IDLE.
- `Stall=0`, `imem_ready=0` (fetch incomplete):
  - IF/ID loads a bubble: `ValidD=0`, `InstrD=0`; `PCD` holds.
  - `PCF` holds.
  - If `redirect`: `pend_v` goes to 1 and `pend_pc` loads `target` (IDLE to PENDING).
  - Otherwise `pend_v` and `pend_pc` hold.
- Delay slot: the instruction at `PCD+4` is fetched and enters D before any redirect takes effect. No flush is ever generated.
- `redirect` while `pend_v=1` cannot arise, because D holds a bubble throughout PENDING. If it does occur, `redirect` wins and overwrites the PC choice; `pend_v` still clears on fetch completion.
- `PCPlus4D` and `PCPlus8D` are combinational from `PCD`.

## Timing
- Reset (`reset_n=0` at an edge):
  - `PCF=RESET_PC`.
  - `InstrD=0`, `PCD=0`, `ValidD=0`.
  - `pend_v=0`, `pend_pc=0`.
  - Reset dominates `Stall` and abandons any pending redirect.
- Latency: a word fetched at edge N is on `InstrD` after edge N, i.e. one cycle.
- A redirect decided in D in cycle N reaches `PCF` after edge N when `imem_ready=1`.
- With `imem_ready=0`, the redirect reaches `PCF` after the edge on which the delay-slot fetch completes. The stage adds zero extra cycles beyond the memory wait.
- `imem_addr` is stable for the whole cycle, changing only at `clk` edges.
- Throughput is one instruction per cycle with `imem_ready=1` and `Stall=0`.

## Test plan
- Reset then 4 cycles, `imem_ready=1`, NOP stream:
  - `PCF` sequence is 0x3000, 0x3004, 0x3008, 0x300C.
  - `ValidD=0` for the first cycle, then `PCD` tracks `PCF-4`.
- `beq` at 0x3000 with imm=0x0003 and `Branch=1`:
  - D gets the delay slot 0x3004.
  - `PCF` then equals 0x3010.
- `jal` at 0x3008 with index 0x0000C40 (word address of 0x3100):
  - `PCPlus8D=0x3010`.
  - `PCF` after the delay slot equals 0x0000_3100.
- `jr` with `JrTarget=0x3020` while `imem_ready=0` for 2 cycles:
  - Two bubbles (`ValidD=0`) and `pend_v=1`.
  - On ready, the delay slot 0x3xx4 enters D and `PCF=0x3020`.
- `Stall=1` for 3 cycles during a `Branch=1`:
  - `PCF`, `InstrD` and `PCD` are unchanged.
  - The redirect applies on the first unstalled edge.
- `reset_n=0` while `pend_v=1`:
  - Next `PCF=0x3000`, `pend_v=0`, `ValidD=0`.
  - The pending target is never fetched.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// pending-redirect register that parks a branch/jump target while imem stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        IfJ,
    input  logic        IfJal,
    input  logic        IfJr,
    input  logic [31:0] JrTarget,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        dbg_state_o
);

    // Handshake: imem_ready=1 means imem_rdata is the word at imem_addr this
    // cycle; the fetch completes on the next rising edge unless Stall is high.

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic        valid_q, valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        pend_v;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4d;
    logic [31:0] branch_off;

    assign pc_plus4d  = pcd_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign redirect   = valid_q & (Branch | IfJ | IfJal | IfJr);

    always_comb begin
        target = pc_plus4d + branch_off;
        if (IfJr) begin
            target = JrTarget;
        end else if (IfJ | IfJal) begin
            target = {pc_plus4d[31:28], instr_q[25:0], 2'b00};
        end
    end

    // Redirect FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect FSM: next state
    always_comb begin
        state_d = state_q;
        if (!Stall) begin
            if (imem_ready) begin
                state_d = ST_IDLE;
            end else if (redirect) begin
                state_d = ST_PENDING;
            end
        end
    end

    // Redirect FSM: outputs
    always_comb begin
        pend_v      = (state_q == ST_PENDING);
        dbg_state_o = state_q;
    end

    // Datapath next state; a live redirect overrides any parked target.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        valid_d   = valid_q;
        pend_pc_d = pend_pc_q;
        if (!Stall) begin
            if (imem_ready) begin
                instr_d = imem_rdata;
                pcd_d   = pc_q;
                valid_d = 1'b1;
                if (redirect) begin
                    pc_d = target;
                end else if (pend_v) begin
                    pc_d = pend_pc_q;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end else begin
                instr_d = 32'd0;
                valid_d = 1'b0;
                if (redirect) begin
                    pend_pc_d = target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            pcd_q     <= 32'd0;
            valid_q   <= 1'b0;
            pend_pc_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            valid_q   <= valid_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign ValidD    = valid_q;
    assign PCPlus4D  = pc_plus4d;
    assign PCPlus8D  = pcd_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: small program ROM, hand-computed PC/IF-ID
// expectations after each rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Stall;
    logic        Branch;
    logic        IfJ;
    logic        IfJal;
    logic        IfJr;
    logic [31:0] JrTarget;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [31:0] PCPlus8D;
    logic        ValidD;
    logic        dbg_state_o;

    logic [31:0] prog [0:63];
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [31:0] BEQ_P3  = 32'h1000_0003;
    localparam logic [31:0] BEQ_M4  = 32'h1000_FFFC;
    localparam logic [31:0] JAL_100 = 32'h0C00_0C40;
    localparam logic [31:0] JR_31   = 32'h03E0_0008;
    localparam logic [31:0] J_040   = 32'h0800_0C10;

    fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Stall      (Stall),
        .Branch     (Branch),
        .IfJ        (IfJ),
        .IfJal      (IfJal),
        .IfJr       (IfJr),
        .JrTarget   (JrTarget),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .PCPlus8D   (PCPlus8D),
        .ValidD     (ValidD),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // Program ROM covering 0x3000..0x30FC; everything else reads as NOP.
    always_comb begin
        imem_rdata = 32'd0;
        if (imem_addr >= 32'h3000 && imem_addr < 32'h3100) begin
            imem_rdata = prog[imem_addr[7:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_f(input string tag, input logic [31:0] pcf, input logic valid,
                            input logic [31:0] pcd, input logic [31:0] instr, input logic pend);
        check({tag, ".PCF"}, PCF, pcf);
        check({tag, ".imem_addr"}, imem_addr, pcf);
        check({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, valid});
        check({tag, ".PCD"}, PCD, pcd);
        check({tag, ".InstrD"}, InstrD, instr);
        check({tag, ".pend"}, {31'd0, dbg_state_o}, {31'd0, pend});
    endtask

    task automatic idle_ctrl();
        Stall = 1'b0; Branch = 1'b0; IfJ = 1'b0; IfJal = 1'b0; IfJr = 1'b0;
        JrTarget = 32'd0; imem_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_ctrl();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    initial begin
        clear_prog();
        idle_ctrl();
        reset_n = 1'b0;

        // NOP stream after reset
        do_reset();
        expect_f("rst", 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        expect_f("seq1", 32'h3004, 1'b1, 32'h3000, 32'h0, 1'b0);
        step();
        expect_f("seq2", 32'h3008, 1'b1, 32'h3004, 32'h0, 1'b0);
        step();
        expect_f("seq3", 32'h300C, 1'b1, 32'h3008, 32'h0, 1'b0);
        check("seq3.PCPlus4D", PCPlus4D, 32'h300C);
        check("seq3.PCPlus8D", PCPlus8D, 32'h3010);

        // beq forward, then beq backward (negative offset)
        clear_prog();
        prog[0] = BEQ_P3;
        prog[4] = BEQ_M4;
        do_reset();
        step();
        expect_f("beq.d", 32'h3004, 1'b1, 32'h3000, BEQ_P3, 1'b0);
        Branch = 1'b1;
        step();
        Branch = 1'b0;
        expect_f("beq.slot", 32'h3010, 1'b1, 32'h3004, 32'h0, 1'b0);
        step();
        expect_f("bneg.d", 32'h3014, 1'b1, 32'h3010, BEQ_M4, 1'b0);
        Branch = 1'b1;
        step();
        Branch = 1'b0;
        expect_f("bneg.slot", 32'h3004, 1'b1, 32'h3014, 32'h0, 1'b0);

        // jal at 0x3008 to 0x3100
        clear_prog();
        prog[2] = JAL_100;
        do_reset();
        step();
        step();
        step();
        expect_f("jal.d", 32'h300C, 1'b1, 32'h3008, JAL_100, 1'b0);
        check("jal.PCPlus8D", PCPlus8D, 32'h3010);
        IfJal = 1'b1;
        step();
        IfJal = 1'b0;
        expect_f("jal.slot", 32'h3100, 1'b1, 32'h300C, 32'h0, 1'b0);

        // jr with a 2-cycle memory wait; IfJr left high during bubbles
        clear_prog();
        prog[0] = JR_31;
        do_reset();
        step();
        expect_f("jr.d", 32'h3004, 1'b1, 32'h3000, JR_31, 1'b0);
        IfJr = 1'b1;
        JrTarget = 32'h3020;
        imem_ready = 1'b0;
        step();
        JrTarget = 32'h3040;
        expect_f("jr.wait1", 32'h3004, 1'b0, 32'h3000, 32'h0, 1'b1);
        step();
        expect_f("jr.wait2", 32'h3004, 1'b0, 32'h3000, 32'h0, 1'b1);
        IfJr = 1'b0;
        imem_ready = 1'b1;
        step();
        expect_f("jr.slot", 32'h3020, 1'b1, 32'h3004, 32'h0, 1'b0);
        step();
        expect_f("jr.tgt", 32'h3024, 1'b1, 32'h3020, 32'h0, 1'b0);

        // jr to top of address space: PC wraps to 0
        IfJr = 1'b1;
        JrTarget = 32'hFFFF_FFFC;
        step();
        IfJr = 1'b0;
        expect_f("wrap.jr", 32'hFFFF_FFFC, 1'b1, 32'h3024, 32'h0, 1'b0);
        step();
        expect_f("wrap.pc", 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
        check("wrap.PCPlus4D", PCPlus4D, 32'h0);
        check("wrap.PCPlus8D", PCPlus8D, 32'h4);

        // Stall for 3 cycles with Branch asserted; imem_ready ignored
        clear_prog();
        prog[0] = BEQ_P3;
        do_reset();
        step();
        Branch = 1'b1;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 1) ? 1'b0 : 1'b1;
            step();
            expect_f($sformatf("stall%0d", i), 32'h3004, 1'b1, 32'h3000, BEQ_P3, 1'b0);
        end
        Stall = 1'b0;
        imem_ready = 1'b1;
        step();
        Branch = 1'b0;
        expect_f("stall.rel", 32'h3010, 1'b1, 32'h3004, 32'h0, 1'b0);

        // Reset abandons a pending j
        clear_prog();
        prog[0] = J_040;
        do_reset();
        step();
        IfJ = 1'b1;
        imem_ready = 1'b0;
        step();
        expect_f("jpend", 32'h3004, 1'b0, 32'h3000, 32'h0, 1'b1);
        IfJ = 1'b0;
        imem_ready = 1'b1;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        expect_f("jpend.rst", 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        expect_f("jpend.after", 32'h3004, 1'b1, 32'h3000, J_040, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
